// File: rtl/led_pattern_gen.sv
// led_pattern_gen -- board-status LED driver.
//
// A prescaled tick steps one of four patterns across LED[NUM_LEDS-1:1]
// (binary count, bouncing scanner, PWM breathe, hold). LED[NUM_LEDS] is a
// pulse-stretched activity indicator for the asynchronous ACT_IN line.
//
// Optional feature macro: LED_PATTERN_BREATHE_EN
//   defined   -> MODE=2 is the PWM breathe pattern (duty / pwm_cnt present)
//   undefined -> breathe logic removed; MODE=2 aliases MODE=0, sharing its
//                count state, so 0<->2 switches do not reinitialise.

module led_pattern_gen #(
    parameter int NUM_LEDS       = 8,
    parameter int DIV_WIDTH      = 24,
    parameter int STRETCH_CYCLES = 65536
) (
    input  logic              SYS_CLK,
    input  logic              RESETN,
    input  logic              CLR_N,
    input  logic [1:0]        MODE,
    input  logic              ACT_IN,
    output logic              TICK,
    output logic [NUM_LEDS:1] LED
);

    localparam int P  = NUM_LEDS - 1;
    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_SCAN    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_HOLD    = 2'd3;

    localparam logic [P-1:0] POS_INIT = {{(P-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Clear synchroniser
    // ------------------------------------------------------------------
    logic [1:0] clr_sync_q;
    logic       clr_active;

    // Two-flop synchroniser; resets high so reset itself never reads as a clear.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (!RESETN) begin
            clr_sync_q <= 2'b11;
        end else begin
            clr_sync_q <= {clr_sync_q[0], CLR_N};
        end
    end

    assign clr_active = ~clr_sync_q[1];

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic                 tick_evt;
    logic                 tick_q;

    // The edge on which div_cnt wraps from all-ones is the tick event.
    assign tick_evt = ~clr_active & (&div_cnt_q);

    // Free-running prescaler, held at zero while clear is active.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= clr_active ? '0 : div_cnt_q + 1'b1;
            tick_q    <= tick_evt;
        end
    end

    // ------------------------------------------------------------------
    // Mode tracking
    // ------------------------------------------------------------------
    logic [1:0] eff_mode;
    logic [1:0] mode_q;
    logic [1:0] last_mode_q;
    logic       reinit;

    // Effective mode and reinit decision: entering a running mode from a
    // different one restarts it, except when simply leaving hold.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value on every
        // path (defaults first) so no latches are inferred.
`ifdef LED_PATTERN_BREATHE_EN
        eff_mode = MODE;
`else
        eff_mode = (MODE == MODE_BREATHE) ? MODE_COUNT : MODE;
`endif
        reinit = (eff_mode != MODE_HOLD) && (eff_mode != mode_q) &&
                 !((mode_q == MODE_HOLD) && (eff_mode == last_mode_q));
    end

    // Remember the current mode and the last non-hold mode.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            mode_q      <= MODE_COUNT;
            last_mode_q <= MODE_COUNT;
        end else begin
            mode_q <= eff_mode;
            if (eff_mode != MODE_HOLD) begin
                last_mode_q <= eff_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Count and scan pattern state
    // ------------------------------------------------------------------
    logic [P-1:0] cnt_q, cnt_d;
    logic [P-1:0] pos_q, pos_d;
    logic         scan_up_q, scan_up_d;

    // Next-state for count and scan; only the active mode steps on a tick.
    always_comb begin
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        scan_up_d = scan_up_q;
        if (clr_active) begin
            cnt_d     = '0;
            pos_d     = POS_INIT;
            scan_up_d = 1'b1;
        end else if (eff_mode == MODE_COUNT) begin
            if (reinit) begin
                cnt_d = '0;
            end else if (tick_evt) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (eff_mode == MODE_SCAN) begin
            if (reinit) begin
                pos_d     = POS_INIT;
                scan_up_d = 1'b1;
            end else if (tick_evt) begin
                if (scan_up_q) begin
                    pos_d = pos_q << 1;
                    if (pos_d[P-1]) scan_up_d = 1'b0;
                end else begin
                    pos_d = pos_q >> 1;
                    if (pos_d[0]) scan_up_d = 1'b1;
                end
            end
        end
    end

    // Count and scan registers.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q     <= '0;
            pos_q     <= POS_INIT;
            scan_up_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            scan_up_q <= scan_up_d;
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    // ------------------------------------------------------------------
    // Breathe pattern state
    // ------------------------------------------------------------------
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic       duty_up_q, duty_up_d;
    logic       breathe_on;

    // Duty bounces 0..255..0 one step per tick; pwm_cnt free-runs.
    always_comb begin
        duty_d     = duty_q;
        duty_up_d  = duty_up_q;
        pwm_cnt_d  = pwm_cnt_q + 8'd1;
        breathe_on = (pwm_cnt_q < duty_q);
        if (clr_active) begin
            duty_d     = '0;
            duty_up_d  = 1'b1;
            pwm_cnt_d  = '0;
            breathe_on = 1'b0;
        end else if (eff_mode == MODE_BREATHE) begin
            if (reinit) begin
                duty_d     = '0;
                duty_up_d  = 1'b1;
                pwm_cnt_d  = '0;
                breathe_on = 1'b0;
            end else if (tick_evt) begin
                if (duty_up_q) begin
                    duty_d = duty_q + 8'd1;
                    if (duty_d == 8'hFF) duty_up_d = 1'b0;
                end else begin
                    duty_d = duty_q - 8'd1;
                    if (duty_d == 8'h00) duty_up_d = 1'b1;
                end
            end
        end
    end

    // Breathe registers.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            duty_q    <= '0;
            duty_up_q <= 1'b1;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            duty_up_q <= duty_up_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pattern LED output register
    // ------------------------------------------------------------------
    logic [P-1:0] led_q, led_d;

    // Pattern LEDs follow the next state so count/scan change with TICK.
    always_comb begin
        led_d = led_q;
        if (clr_active) begin
            led_d = '0;
        end else begin
            case (eff_mode)
                MODE_COUNT:   led_d = cnt_d;
                MODE_SCAN:    led_d = pos_d;
`ifdef LED_PATTERN_BREATHE_EN
                MODE_BREATHE: led_d = {P{breathe_on}};
`endif
                default:      led_d = led_q;
            endcase
        end
    end

    // Pattern LED register; holding it is what freezes the display in hold.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    // ------------------------------------------------------------------
    // Activity stretcher
    // ------------------------------------------------------------------
    logic [1:0]    act_sync_q;
    logic          act_hist_q;
    logic [SW-1:0] stretch_q, stretch_d;
    logic          act_led_q;

    // Any level change reloads the stretch counter, otherwise it counts down.
    always_comb begin
        stretch_d = stretch_q;
        if (act_sync_q[1] != act_hist_q) begin
            stretch_d = SW'(STRETCH_CYCLES);
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - 1'b1;
        end
    end

    // Activity synchroniser, history flop and stretch counter.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            act_sync_q <= 2'b00;
            act_hist_q <= 1'b0;
            stretch_q  <= '0;
            act_led_q  <= 1'b0;
        end else begin
            act_sync_q <= {act_sync_q[0], ACT_IN};
            act_hist_q <= act_sync_q[1];
            stretch_q  <= stretch_d;
            act_led_q  <= (stretch_d != '0);
        end
    end

    assign TICK = tick_q;
    assign LED  = {act_led_q, led_q};

endmodule
